// File: rtl/wl_search_ctrl.sv
// rtl/wl_search_ctrl.sv - binary-search sequencer for the smallest word length whose error stays in budget
module wl_search_ctrl #(
    parameter int WL_MIN     = 4,
    parameter int WL_MAX     = 28,
    parameter int WL_W       = 5,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = 140000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            go_i,
    input  logic [63:0]     err_budget_i,
    output logic [WL_W-1:0] wl_cfg_o,
    output logic            coll_start_o,
    input  logic [63:0]     coll_data_i,
    input  logic            coll_valid_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            found_o,
    output logic            timeout_err_o,
    output logic [WL_W-1:0] best_wl_o,
    output logic [63:0]     best_err_o,
    output logic [7:0]      eval_cnt_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DECIDE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // One spare bit on lo/hi/cand keeps cand+1 and lo+hi from wrapping.
    localparam int CW = WL_W + 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] MIN_C       = CW'(WL_MIN);
    localparam logic [CW-1:0] MAX_C       = CW'(WL_MAX);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   lo_q, lo_d, hi_q, hi_d, cand_q, cand_d;
    logic            first_q, first_d;
    logic [63:0]     budget_q, budget_d, res_q, res_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [WL_W-1:0] wl_cfg_q, wl_cfg_d, best_wl_q, best_wl_d;
    logic            found_q, found_d, tmo_q, tmo_d;
    logic [63:0]     best_err_q, best_err_d;
    logic [7:0]      eval_cnt_q, eval_cnt_d;

    logic            pass;
    logic [CW-1:0]   lo_n, hi_n, mid;

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        cand_d     = cand_q;
        first_d    = first_q;
        budget_d   = budget_q;
        res_d      = res_q;
        settle_d   = settle_q;
        timer_d    = timer_q;
        wl_cfg_d   = wl_cfg_q;
        best_wl_d  = best_wl_q;
        found_d    = found_q;
        tmo_d      = tmo_q;
        best_err_d = best_err_q;
        eval_cnt_d = eval_cnt_q;

        // Narrowed interval after the current result; only consumed in DECIDE.
        pass = (res_q <= budget_q);
        lo_n = lo_q;
        hi_n = hi_q;
        if (first_q) begin
            hi_n = MAX_C;
        end else if (pass) begin
            hi_n = cand_q;
        end else begin
            lo_n = cand_q + 1'b1;
        end
        mid = (lo_n + hi_n) >> 1;

        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    budget_d   = err_budget_i;
                    lo_d       = MIN_C;
                    hi_d       = MAX_C;
                    cand_d     = MAX_C;
                    first_d    = 1'b1;
                    found_d    = 1'b0;
                    tmo_d      = 1'b0;
                    best_wl_d  = '0;
                    best_err_d = '0;
                    eval_cnt_d = '0;
                    wl_cfg_d   = MAX_C[WL_W-1:0];
                    settle_d   = '0;
                    state_d    = S_APPLY;
                end
            end
            S_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_START;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_START: begin
                if (eval_cnt_q != 8'hFF) begin
                    eval_cnt_d = eval_cnt_q + 8'd1;
                end
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (coll_valid_i) begin
                    res_d   = coll_data_i;
                    state_d = S_DECIDE;
                end else if (timer_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    found_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DECIDE: begin
                if (first_q && !pass) begin
                    found_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    first_d = 1'b0;
                    lo_d    = lo_n;
                    hi_d    = hi_n;
                    if (pass) begin
                        best_wl_d  = cand_q[WL_W-1:0];
                        best_err_d = res_q;
                    end
                    if (lo_n < hi_n) begin
                        cand_d   = mid;
                        wl_cfg_d = mid[WL_W-1:0];
                        settle_d = '0;
                        state_d  = S_APPLY;
                    end else begin
                        found_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            cand_q     <= '0;
            first_q    <= 1'b0;
            budget_q   <= '0;
            res_q      <= '0;
            settle_q   <= '0;
            timer_q    <= '0;
            wl_cfg_q   <= MAX_C[WL_W-1:0];
            best_wl_q  <= '0;
            found_q    <= 1'b0;
            tmo_q      <= 1'b0;
            best_err_q <= '0;
            eval_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            cand_q     <= cand_d;
            first_q    <= first_d;
            budget_q   <= budget_d;
            res_q      <= res_d;
            settle_q   <= settle_d;
            timer_q    <= timer_d;
            wl_cfg_q   <= wl_cfg_d;
            best_wl_q  <= best_wl_d;
            found_q    <= found_d;
            tmo_q      <= tmo_d;
            best_err_q <= best_err_d;
            eval_cnt_q <= eval_cnt_d;
        end
    end

    assign wl_cfg_o      = wl_cfg_q;
    assign coll_start_o  = (state_q == S_START);
    assign done_o        = (state_q == S_DONE);
    assign busy_o        = (state_q != S_IDLE);
    assign found_o       = found_q;
    assign timeout_err_o = tmo_q;
    assign best_wl_o     = best_wl_q;
    assign best_err_o    = best_err_q;
    assign eval_cnt_o    = eval_cnt_q;

endmodule

// File: tb/tb_wl_search_ctrl.sv
// tb/tb_wl_search_ctrl.sv - directed and randomized bench for wl_search_ctrl with a collector model
module tb_wl_search_ctrl;
    localparam int WL_MIN = 4;
    localparam int WL_MAX = 28;
    localparam int WL_W   = 5;
    localparam int SETTLE = 4;
    localparam int TMO    = 40;

    logic            clk = 1'b0;
    logic            rstn;
    logic            go;
    logic [63:0]     err_budget;
    logic [WL_W-1:0] wl_cfg_o;
    logic            coll_start_o;
    logic [63:0]     coll_data;
    logic            coll_valid;
    logic            busy_o, done_o, found_o, timeout_err_o;
    logic [WL_W-1:0] best_wl_o;
    logic [63:0]     best_err_o;
    logic [7:0]      eval_cnt_o;

    logic            model_valid, spur_valid;
    logic [63:0]     model_data;
    int              model_mode;
    logic [63:0]     const_err;
    logic [63:0]     err_tab [0:31];

    int              errors = 0;
    int              checks = 0;
    int              evq[$];
    int              exp_seq[$];
    bit              exp_found, exp_timeout;
    int              exp_best;
    logic [63:0]     exp_berr;

    always #5 clk = ~clk;

    assign coll_valid = model_valid | spur_valid;
    assign coll_data  = spur_valid ? 64'd0 : model_data;

    wl_search_ctrl #(
        .WL_MIN(WL_MIN), .WL_MAX(WL_MAX), .WL_W(WL_W), .SETTLE_CYC(SETTLE), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn), .go_i(go), .err_budget_i(err_budget),
        .wl_cfg_o(wl_cfg_o), .coll_start_o(coll_start_o),
        .coll_data_i(coll_data), .coll_valid_i(coll_valid),
        .busy_o(busy_o), .done_o(done_o), .found_o(found_o), .timeout_err_o(timeout_err_o),
        .best_wl_o(best_wl_o), .best_err_o(best_err_o), .eval_cnt_o(eval_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Modes: 0 err=2^(40-wl), 1 constant, 2 silent, 3 table, 4 like 0 but answers on the timeout cycle.
    function automatic logic [63:0] err_of(input int wl);
        if (model_mode == 1) return const_err;
        if (model_mode == 3) return err_tab[wl];
        return 64'd1 << (40 - wl);
    endfunction

    task automatic ref_search(input logic [63:0] b);
        int lo, hi, mid;
        exp_seq.delete();
        exp_timeout = (model_mode == 2);
        exp_found   = 1'b0;
        exp_best    = 0;
        exp_berr    = '0;
        exp_seq.push_back(WL_MAX);
        if (exp_timeout || err_of(WL_MAX) > b) return;
        lo = WL_MIN;
        hi = WL_MAX;
        while (lo < hi) begin
            mid = (lo + hi) / 2;
            exp_seq.push_back(mid);
            if (err_of(mid) <= b) hi = mid;
            else lo = mid + 1;
        end
        exp_found = 1'b1;
        for (int w = WL_MAX; w >= WL_MIN; w--)
            if (err_of(w) <= b) exp_best = w;
        exp_berr = err_of(exp_best);
    endtask

    // Collector: answers each start after a random WAIT latency.
    initial begin
        int wl_snap, lat;
        model_valid = 1'b0;
        model_data  = '0;
        forever begin
            @(negedge clk);
            model_valid = 1'b0;
            if (coll_start_o === 1'b1 && model_mode != 2) begin
                wl_snap = int'(wl_cfg_o);
                lat = (model_mode == 4) ? TMO : int'($urandom_range(1, 7));
                repeat (lat) @(negedge clk);
                if (busy_o === 1'b1) check("wl_cfg_stable_in_wait", 64'(wl_cfg_o), 64'(wl_snap));
                model_data  = err_of(wl_snap);
                model_valid = 1'b1;
            end
        end
    end

    // Start-pulse width, settle hold and evaluation order monitor.
    initial begin
        int stable;
        logic [WL_W-1:0] prev_wl;
        bit prev_start;
        stable = 0;
        prev_wl = '0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (wl_cfg_o === prev_wl) stable++;
            else stable = 1;
            prev_wl = wl_cfg_o;
            if (coll_start_o === 1'b1) begin
                check("start_width", 64'(prev_start), 64'd0);
                check("settle_hold", 64'(stable > SETTLE), 64'd1);
                evq.push_back(int'(wl_cfg_o));
            end
            prev_start = (coll_start_o === 1'b1);
        end
    end

    task automatic run_search(input string tag, input logic [63:0] b, input bit disturb, input int budget_cyc);
        int starts;
        bit seen_done, go_pend;
        starts = 0;
        seen_done = 1'b0;
        go_pend = 1'b0;
        ref_search(b);
        evq.delete();
        err_budget = b;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check({tag, "_busy_after_go"}, 64'(busy_o), 64'd1);
        check({tag, "_tmo_clr_on_go"}, 64'(timeout_err_o), 64'd0);
        check({tag, "_cnt_clr_on_go"}, 64'(eval_cnt_o), 64'd0);
        if (disturb) spur_valid = 1'b1;
        for (int c = 0; c < budget_cyc && !seen_done; c++) begin
            @(negedge clk);
            spur_valid = 1'b0;
            go = 1'b0;
            err_budget = b;
            if (go_pend) begin
                go = 1'b1;
                err_budget = 64'd0;
                go_pend = 1'b0;
            end
            if (done_o === 1'b1) begin
                seen_done = 1'b1;
            end else if (coll_start_o === 1'b1) begin
                starts++;
                if (disturb && starts == 1) go_pend = 1'b1;
            end
        end
        go = 1'b0;
        check({tag, "_done_seen"}, 64'(seen_done), 64'd1);
        if (seen_done) begin
            check({tag, "_found"}, 64'(found_o), 64'(exp_found));
            check({tag, "_best_wl"}, 64'(best_wl_o), 64'(exp_best));
            check({tag, "_best_err"}, best_err_o, exp_berr);
            check({tag, "_eval_cnt"}, 64'(eval_cnt_o), 64'(exp_seq.size()));
            check({tag, "_timeout"}, 64'(timeout_err_o), 64'(exp_timeout));
            check({tag, "_busy_in_done"}, 64'(busy_o), 64'd1);
            @(negedge clk);
            check({tag, "_done_width"}, 64'(done_o), 64'd0);
            check({tag, "_busy_after"}, 64'(busy_o), 64'd0);
            check({tag, "_found_held"}, 64'(found_o), 64'(exp_found));
            check({tag, "_best_held"}, 64'(best_wl_o), 64'(exp_best));
            check({tag, "_tmo_held"}, 64'(timeout_err_o), 64'(exp_timeout));
        end
        check({tag, "_n_evals"}, 64'(evq.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < evq.size(); i++)
            check($sformatf("%s_eval%0d_wl", tag, i), 64'(evq[i]), 64'(exp_seq[i]));
    endtask

    initial begin
        int n;
        bit saw_done;
        logic [63:0] b;
        int t;
        rstn = 1'b0;
        go = 1'b0;
        err_budget = '0;
        spur_valid = 1'b0;
        model_mode = 0;
        const_err = '0;
        for (int i = 0; i < 32; i++) err_tab[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_start", 64'(coll_start_o), 64'd0);
        check("rst_found", 64'(found_o), 64'd0);
        check("rst_tmo", 64'(timeout_err_o), 64'd0);
        check("rst_best_wl", 64'(best_wl_o), 64'd0);
        check("rst_best_err", best_err_o, 64'd0);
        check("rst_eval_cnt", 64'(eval_cnt_o), 64'd0);
        check("rst_wl_cfg", 64'(wl_cfg_o), 64'(WL_MAX));
        rstn = 1'b1;
        @(negedge clk);

        model_mode = 0;
        run_search("pow2", 64'd1 << 28, 1'b0, 1000);
        run_search("zero_budget", 64'd0, 1'b0, 1000);
        model_mode = 1;
        const_err = 64'd1000;
        run_search("eq_budget", 64'd1000, 1'b0, 1000);
        model_mode = 2;
        run_search("silent", 64'd1 << 28, 1'b0, 1000);
        model_mode = 4;
        run_search("valid_on_tmo", 64'd1 << 28, 1'b0, 2000);

        // Reset during WAIT of the second evaluation.
        model_mode = 0;
        err_budget = 64'd1 << 28;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        for (int c = 0; c < 300 && n < 2; c++) begin
            @(negedge clk);
            if (coll_start_o === 1'b1) n++;
        end
        check("rst_mid_reached", 64'(n), 64'd2);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        check("rst_mid_done", 64'(done_o), 64'd0);
        check("rst_mid_wl_cfg", 64'(wl_cfg_o), 64'(WL_MAX));
        check("rst_mid_eval_cnt", 64'(eval_cnt_o), 64'd0);
        check("rst_mid_best_wl", 64'(best_wl_o), 64'd0);
        rstn = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        check("rst_mid_no_done", 64'(saw_done), 64'd0);
        run_search("after_rst", 64'd1 << 28, 1'b0, 1000);

        run_search("disturbed", 64'd1 << 28, 1'b1, 1000);

        model_mode = 3;
        for (int r = 0; r < 5; r++) begin
            b = {1'b0, $urandom, $urandom} >> 1;
            if (b == 0) b = 64'd77;
            t = (r == 4) ? WL_MAX + 1 : int'($urandom_range(WL_MIN, WL_MAX));
            for (int w = 0; w < 32; w++)
                err_tab[w] = (w >= t) ? (b >> $urandom_range(0, 3)) : (b + 64'd1 + 64'($urandom));
            run_search($sformatf("rand%0d", r), b, 1'b0, 1000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
